tone_meas: RTL and testbench

Receive-side counterpart of the square-wave tone generator: measures the half-period of an incoming square wave in clock cycles and reports it as a divider value. A tone generated with divider N gives div_out = N. It sits on the input side of the tone path for loopback self-test and tone-detection use. It also flags when the measured value has been stable long enough to count as locked, and when the input has stopped toggling.

---
 rtl/tone_meas.sv | 222 ++++++++++++++++++++++
 tb/tb_tone_meas.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/tone_meas.sv
// Tone half-period meter: measures the spacing of edges on an asynchronous square wave
// and reports it as a divider value, with lock and loss-of-signal indications.

module tone_meas_chk #(
    parameter int WIDTH_COUNTER = 10
) (
    input logic                     clk,
    input logic                     rst,
    input logic                     sample_stb,
    input logic                     locked,
    input logic                     timeout,
    input logic [WIDTH_COUNTER-1:0] div_out
);

    stb_excludes_timeout: assert property (@(posedge clk) disable iff (rst)
        sample_stb |-> !timeout);

    locked_excludes_timeout: assert property (@(posedge clk) disable iff (rst)
        locked |-> !timeout);

    sample_nonzero: assert property (@(posedge clk) disable iff (rst)
        sample_stb |-> (div_out != '0));

endmodule

module tone_meas #(
    parameter int WIDTH_COUNTER = 10,
    parameter int STABLE_COUNT  = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     tone_in,
    output logic [WIDTH_COUNTER-1:0] div_out,
    output logic                     sample_stb,
    output logic                     locked,
    output logic                     timeout
);

    localparam int MATCH_W = $clog2(STABLE_COUNT + 1);
    localparam logic [WIDTH_COUNTER-1:0] CNT_MAX   = {WIDTH_COUNTER{1'b1}};
    localparam logic [WIDTH_COUNTER-1:0] CNT_ONE   = WIDTH_COUNTER'(1);
    localparam logic [MATCH_W-1:0]       MATCH_MAX = MATCH_W'(STABLE_COUNT);
    localparam logic [MATCH_W-1:0]       MATCH_ONE = MATCH_W'(1);
    localparam logic [MATCH_W-1:0]       MATCH_ZRO = MATCH_W'(0);

    typedef enum logic [1:0] {
        ST_SEARCH = 2'b00,
        ST_TRACK  = 2'b01,
        ST_LOCKED = 2'b10
    } state_t;

    logic                     sync1_r;
    logic                     sync2_r;
    logic                     prev_r;
    logic                     edge_s;
    logic                     sat_s;
    logic [WIDTH_COUNTER-1:0] cnt_r;
    logic [MATCH_W-1:0]       match_r;
    logic [MATCH_W-1:0]       match_upd_s;
    logic [MATCH_W-1:0]       match_nxt_s;
    state_t                   state_r;
    state_t                   state_nxt_s;
    logic [WIDTH_COUNTER-1:0] div_r;
    logic [WIDTH_COUNTER-1:0] div_nxt_s;
    logic                     stb_r;
    logic                     stb_nxt_s;
    logic                     locked_r;
    logic                     locked_nxt_s;
    logic                     timeout_r;
    logic                     timeout_nxt_s;

    assign edge_s = sync2_r ^ prev_r;
    assign sat_s  = (cnt_r == CNT_MAX);

    // Synchronizer pair plus previous-level register for edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
            prev_r  <= 1'b0;
        end else begin
            sync1_r <= tone_in;
            sync2_r <= sync1_r;
            prev_r  <= sync2_r;
        end
    end

    // Half-period counter: restarts at 1 on every edge, saturates instead of wrapping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= '0;
        end else if (edge_s) begin
            cnt_r <= CNT_ONE;
        end else if (!sat_s) begin
            cnt_r <= cnt_r + CNT_ONE;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Match count a sample would produce; zero marks the first sample after SEARCH
    always_comb begin
        match_upd_s = MATCH_ONE;
        if (match_r == MATCH_ZRO) begin
            match_upd_s = MATCH_ONE;
        end else if (cnt_r == div_r) begin
            if (match_r >= MATCH_MAX) begin
                match_upd_s = MATCH_MAX;
            end else begin
                match_upd_s = match_r + MATCH_ONE;
            end
        end else begin
            match_upd_s = MATCH_ONE;
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_SEARCH;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; an edge coinciding with saturation is still a sample
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_SEARCH: begin
                if (edge_s) begin
                    state_nxt_s = ST_TRACK;
                end else begin
                    state_nxt_s = ST_SEARCH;
                end
            end
            ST_TRACK, ST_LOCKED: begin
                if (edge_s) begin
                    if (match_upd_s >= MATCH_MAX) begin
                        state_nxt_s = ST_LOCKED;
                    end else begin
                        state_nxt_s = ST_TRACK;
                    end
                end else if (sat_s) begin
                    state_nxt_s = ST_SEARCH;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            default: begin
                state_nxt_s = ST_SEARCH;
            end
        endcase
    end

    // Output/datapath next values, registered below
    always_comb begin
        div_nxt_s     = div_r;
        stb_nxt_s     = 1'b0;
        match_nxt_s   = match_r;
        timeout_nxt_s = timeout_r;
        case (state_r)
            ST_SEARCH: begin
                if (edge_s) begin
                    timeout_nxt_s = 1'b0;
                end else begin
                    timeout_nxt_s = timeout_r;
                end
            end
            ST_TRACK, ST_LOCKED: begin
                if (edge_s) begin
                    div_nxt_s   = cnt_r;
                    stb_nxt_s   = 1'b1;
                    match_nxt_s = match_upd_s;
                end else if (sat_s) begin
                    timeout_nxt_s = 1'b1;
                    match_nxt_s   = MATCH_ZRO;
                end else begin
                    match_nxt_s = match_r;
                end
            end
            default: begin
                match_nxt_s = MATCH_ZRO;
            end
        endcase
        locked_nxt_s = (state_nxt_s == ST_LOCKED);
    end

    // Registered outputs and match counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_r     <= '0;
            stb_r     <= 1'b0;
            locked_r  <= 1'b0;
            timeout_r <= 1'b0;
            match_r   <= MATCH_ZRO;
        end else begin
            div_r     <= div_nxt_s;
            stb_r     <= stb_nxt_s;
            locked_r  <= locked_nxt_s;
            timeout_r <= timeout_nxt_s;
            match_r   <= match_nxt_s;
        end
    end

    assign div_out    = div_r;
    assign sample_stb = stb_r;
    assign locked     = locked_r;
    assign timeout    = timeout_r;

    tone_meas_chk #(
        .WIDTH_COUNTER(WIDTH_COUNTER)
    ) u_chk (
        .clk       (clk),
        .rst       (rst),
        .sample_stb(stb_r),
        .locked    (locked_r),
        .timeout   (timeout_r),
        .div_out   (div_r)
    );

endmodule

// File: tb/tb_tone_meas.sv
// Directed bench for tone_meas: tone generator on tone_in, cycle-exact checks of
// samples, lock, timeout, saturation boundaries and asynchronous reset.

module tb_tone_meas;

    logic       clk = 1'b0;
    logic       rst;
    logic       tone_in;
    logic [9:0] div_out;
    logic       sample_stb;
    logic       locked;
    logic       timeout;

    int n_checks = 0;
    int n_fail   = 0;
    int gen_half = 0;
    int gen_cnt  = 0;
    int stb_cnt  = 0;
    int to_cnt   = 0;

    tone_meas #(
        .WIDTH_COUNTER(10),
        .STABLE_COUNT (3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .tone_in   (tone_in),
        .div_out   (div_out),
        .sample_stb(sample_stb),
        .locked    (locked),
        .timeout   (timeout)
    );

    initial forever #5 clk = ~clk;

    // Advance one clock, run the tone generator, and accumulate stb/timeout counts
    task automatic tick();
        @(posedge clk);
        #1;
        if (gen_half > 0) begin
            gen_cnt++;
            if (gen_cnt >= gen_half) begin
                tone_in = ~tone_in;
                gen_cnt = 0;
            end
        end else begin
            gen_cnt = 0;
        end
        if (sample_stb === 1'b1) stb_cnt++;
        if (timeout === 1'b1) to_cnt++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        rst     = 1'b1;
        tone_in = 1'b0;
        tick();
        tick();
        chk("rst_div",     32'(div_out),    32'd0);
        chk("rst_stb",     32'(sample_stb), 32'd0);
        chk("rst_locked",  32'(locked),     32'd0);
        chk("rst_timeout", 32'(timeout),    32'd0);

        // div = 5 tone from reset
        rst      = 1'b0;
        tone_in  = 1'b1;
        gen_cnt  = 0;
        gen_half = 5;
        repeat (3) tick();
        chk("a_ref_no_stb", 32'(sample_stb), 32'd0);
        chk("a_ref_nolock", 32'(locked),     32'd0);
        repeat (5) tick();
        chk("a_s1_stb",    32'(sample_stb), 32'd1);
        chk("a_s1_div",    32'(div_out),    32'd5);
        chk("a_s1_locked", 32'(locked),     32'd0);
        tick();
        chk("a_stb_width", 32'(sample_stb), 32'd0);
        repeat (4) tick();
        chk("a_s2_stb",    32'(sample_stb), 32'd1);
        chk("a_s2_locked", 32'(locked),     32'd0);
        repeat (4) tick();
        chk("a_pre_lock",  32'(locked),     32'd0);
        tick();
        chk("a_s3_stb",     32'(sample_stb), 32'd1);
        chk("a_s3_div",     32'(div_out),    32'd5);
        chk("a_s3_locked",  32'(locked),     32'd1);
        chk("a_s3_timeout", 32'(timeout),    32'd0);

        // switch to div = 12 while locked on 5
        gen_half = 12;
        repeat (11) tick();
        chk("b_hold_locked", 32'(locked),  32'd1);
        chk("b_hold_div",    32'(div_out), 32'd5);
        tick();
        chk("b_s1_stb",    32'(sample_stb), 32'd1);
        chk("b_s1_div",    32'(div_out),    32'd12);
        chk("b_s1_locked", 32'(locked),     32'd0);
        repeat (12) tick();
        chk("b_s2_div",    32'(div_out),    32'd12);
        chk("b_s2_locked", 32'(locked),     32'd0);
        repeat (11) tick();
        chk("b_pre_lock",  32'(locked),     32'd0);
        tick();
        chk("b_s3_stb",    32'(sample_stb), 32'd1);
        chk("b_s3_locked", 32'(locked),     32'd1);

        // half-period 1: one transitional sample of 4, then 1 every cycle
        gen_half = 1;
        repeat (4) tick();
        chk("c_trans_div",  32'(div_out), 32'd4);
        chk("c_trans_lock", 32'(locked),  32'd0);
        tick();
        chk("c_s1_div", 32'(div_out), 32'd1);
        tick();
        chk("c_s2_stb",    32'(sample_stb), 32'd1);
        chk("c_s2_locked", 32'(locked),     32'd0);
        tick();
        chk("c_s3_locked", 32'(locked), 32'd1);
        stb_cnt = 0;
        repeat (20) tick();
        chk("c_stb_cont",   32'(stb_cnt), 32'd20);
        chk("c_div_cont",   32'(div_out), 32'd1);
        chk("c_lock_cont",  32'(locked),  32'd1);

        // lock on 7, then freeze the tone
        gen_half = 7;
        repeat (30) tick();
        chk("d_locked7", 32'(locked),  32'd1);
        chk("d_div7",    32'(div_out), 32'd7);
        gen_half = 0;
        tick();
        chk("d_last_stb", 32'(sample_stb), 32'd1);
        repeat (1022) tick();
        chk("d_pre_to",     32'(timeout), 32'd0);
        chk("d_pre_locked", 32'(locked),  32'd1);
        tick();
        chk("d_timeout",   32'(timeout),    32'd1);
        chk("d_to_locked", 32'(locked),     32'd0);
        chk("d_to_div",    32'(div_out),    32'd7);
        chk("d_to_stb",    32'(sample_stb), 32'd0);

        // tone resumes: first edge only clears timeout
        tone_in  = ~tone_in;
        gen_cnt  = 0;
        gen_half = 7;
        repeat (2) tick();
        chk("d_to_held", 32'(timeout), 32'd1);
        tick();
        chk("d_to_clear",  32'(timeout),    32'd0);
        chk("d_ref_nostb", 32'(sample_stb), 32'd0);
        stb_cnt = 0;
        repeat (6) tick();
        chk("d_gap_nostb", 32'(stb_cnt), 32'd0);
        tick();
        chk("d_res_stb",    32'(sample_stb), 32'd1);
        chk("d_res_div",    32'(div_out),    32'd7);
        chk("d_res_locked", 32'(locked),     32'd0);

        // half-period 1023: captured exactly, no timeout
        gen_half = 1023;
        to_cnt   = 0;
        repeat (1023) tick();
        chk("e_s1_stb", 32'(sample_stb), 32'd1);
        chk("e_s1_div", 32'(div_out),    32'd1023);
        repeat (1023) tick();
        chk("e_s2_stb",    32'(sample_stb), 32'd1);
        chk("e_s2_div",    32'(div_out),    32'd1023);
        chk("e_s2_locked", 32'(locked),     32'd0);
        chk("e_no_to",     32'(to_cnt),     32'd0);

        // half-period 1024: timeout every half-period, never a sample
        gen_half = 1024;
        stb_cnt  = 0;
        to_cnt   = 0;
        repeat (1023) tick();
        chk("f_to_first", 32'(timeout), 32'd1);
        tick();
        chk("f_to_clear", 32'(timeout), 32'd0);
        repeat (2048) tick();
        chk("f_to_count", 32'(to_cnt),  32'd3);
        chk("f_no_stb",   32'(stb_cnt), 32'd0);
        chk("f_div_hold", 32'(div_out), 32'd1023);

        // asynchronous reset while locked with tone_in high
        gen_half = 5;
        repeat (40) tick();
        for (int i = 0; i < 10; i++) begin
            if (tone_in === 1'b1) break;
            tick();
        end
        gen_half = 0;
        chk("g_locked5", 32'(locked),  32'd1);
        chk("g_div5",    32'(div_out), 32'd5);
        #3;
        rst = 1'b1;
        #1;
        chk("g_arst_div",     32'(div_out),    32'd0);
        chk("g_arst_stb",     32'(sample_stb), 32'd0);
        chk("g_arst_locked",  32'(locked),     32'd0);
        chk("g_arst_timeout", 32'(timeout),    32'd0);
        tick();
        tick();
        rst     = 1'b0;
        stb_cnt = 0;
        repeat (6) tick();
        chk("g_ref_nostb", 32'(stb_cnt), 32'd0);
        chk("g_ref_div",   32'(div_out), 32'd0);
        tone_in = 1'b0;
        repeat (2) tick();
        chk("g_pre_stb", 32'(sample_stb), 32'd0);
        tick();
        chk("g_s1_stb",    32'(sample_stb), 32'd1);
        chk("g_s1_div",    32'(div_out),    32'd6);
        chk("g_s1_locked", 32'(locked),     32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
